// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the serial link blocks (serializer/deserializer).
// State encodings plus a constant-friendly clog2 helper.
package piso_serializer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_GAP   = ST_GAP
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with valid/ready load side.
// Ports: Clk, Rst (sync, active-high), Load_valid/Load_data/Load_ready
// handshake in; Dout/Dout_valid serial out; Busy, Done status.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int IDLE_GAP  = 0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Load_valid,
  input  logic [WIDTH-1:0] Load_data,
  output logic             Load_ready,
  output logic             Dout,
  output logic             Dout_valid,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(WIDTH - 2);
  localparam bit HAS_GAP = (IDLE_GAP > 0);
  localparam logic [3:0] GAP_LAST =
    4'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

  state_e           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic [3:0]       gcnt;

  logic             last;
  logic             accept;
  logic [WIDTH-1:0] shifted;

  assign last = (state == S_SHIFT) &&
                (cnt == CNT_LAST);

  assign Load_ready = (state == S_IDLE) ||
                      (last && !HAS_GAP);

  assign accept = Load_valid && Load_ready;

  // Vacated positions fill with zero, so the
  // register drains to 0 after the last bit and
  // Dout reads 0 whenever no frame is on the line.
  assign shifted = MSB_FIRST ?
    {sreg[WIDTH-2:0], 1'b0} :
    {1'b0, sreg[WIDTH-1:1]};

  assign Dout = MSB_FIRST ?
    sreg[WIDTH-1] : sreg[0];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= S_IDLE;
      sreg       <= '0;
      cnt        <= '0;
      gcnt       <= '0;
      Dout_valid <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            state      <= S_SHIFT;
            sreg       <= Load_data;
            cnt        <= '0;
            Dout_valid <= 1'b1;
            Busy       <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (!last) begin
            sreg <= shifted;
            cnt  <= cnt + 1'b1;
            // Done is registered: raise it on the
            // edge that presents the final bit.
            Done <= (cnt == CNT_PRE);
          end else if (HAS_GAP) begin
            state      <= S_GAP;
            sreg       <= shifted;
            gcnt       <= '0;
            Dout_valid <= 1'b0;
          end else if (accept) begin
            sreg <= Load_data;
            cnt  <= '0;
          end else begin
            state      <= S_IDLE;
            sreg       <= shifted;
            Dout_valid <= 1'b0;
            Busy       <= 1'b0;
          end
        end
        S_GAP: begin
          if (gcnt == GAP_LAST) begin
            state <= S_IDLE;
            Busy  <= 1'b0;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          sreg       <= '0;
          Dout_valid <= 1'b0;
          Busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: two instances (MSB-first no gap,
// LSB-first gap 3) against a cycle-schedule reference model.
module tb_piso_serializer;

  localparam int W = 8;
  localparam int N = 4096;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic         Rst;
  logic         lv[2];
  logic [W-1:0] ld[2];
  logic         lr[2];
  logic         dout[2];
  logic         dv[2];
  logic         bsy[2];
  logic         dn[2];

  piso_serializer #(
    .WIDTH(W), .MSB_FIRST(1'b1), .IDLE_GAP(0)
  ) u0 (
    .Clk(Clk), .Rst(Rst),
    .Load_valid(lv[0]), .Load_data(ld[0]),
    .Load_ready(lr[0]), .Dout(dout[0]),
    .Dout_valid(dv[0]), .Busy(bsy[0]),
    .Done(dn[0])
  );

  piso_serializer #(
    .WIDTH(W), .MSB_FIRST(1'b0), .IDLE_GAP(3)
  ) u1 (
    .Clk(Clk), .Rst(Rst),
    .Load_valid(lv[1]), .Load_data(ld[1]),
    .Load_ready(lr[1]), .Dout(dout[1]),
    .Dout_valid(dv[1]), .Busy(bsy[1]),
    .Done(dn[1])
  );

  int checks = 0;
  int errors = 0;
  int tcur = 0;
  bit chk_en = 1'b0;
  bit acc[2];
  int ready_from[2];

  // expected per-cycle outputs, indexed by cycle number
  bit ev[2][N];
  bit eb[2][N];
  bit ed[2][N];
  bit ebz[2][N];

  function automatic int gap_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  function automatic bit msb_of(input int i);
    return (i == 0);
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got %0h want %0h",
               tag, tcur, got, exp);
    end
  endtask

  // One clock cycle: compare at negedge, advance the
  // model with the inputs of this cycle, then step.
  task automatic cyc();
    int g;
    int idx;
    bit rdy;
    @(negedge Clk);
    for (int i = 0; i < 2; i++) begin
      g = gap_of(i);
      rdy = (tcur >= ready_from[i]);
      if (chk_en) begin
        check($sformatf("u%0d_valid", i), dv[i], ev[i][tcur]);
        check($sformatf("u%0d_dout", i), dout[i], eb[i][tcur]);
        check($sformatf("u%0d_done", i), dn[i], ed[i][tcur]);
        check($sformatf("u%0d_busy", i), bsy[i], ebz[i][tcur]);
        check($sformatf("u%0d_ready", i), lr[i], rdy);
      end
      acc[i] = 1'b0;
      if (Rst) begin
        for (int k = 1; k <= W + g + 2; k++) begin
          idx = tcur + k;
          if (idx < N) begin
            ev[i][idx] = 0; eb[i][idx] = 0;
            ed[i][idx] = 0; ebz[i][idx] = 0;
          end
        end
        ready_from[i] = tcur + 1;
      end else if (lv[i] && rdy) begin
        acc[i] = 1'b1;
        for (int k = 0; k < W; k++) begin
          idx = tcur + 1 + k;
          if (idx < N) begin
            ev[i][idx] = 1'b1;
            eb[i][idx] = msb_of(i) ? ld[i][W-1-k] : ld[i][k];
            ed[i][idx] = (k == W - 1);
            ebz[i][idx] = 1'b1;
          end
        end
        for (int k = 0; k < g; k++) begin
          idx = tcur + W + 1 + k;
          if (idx < N) ebz[i][idx] = 1'b1;
        end
        ready_from[i] = tcur + W + ((g > 0) ? g + 1 : 0);
      end
    end
    tcur++;
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input int i, input logic [W-1:0] d);
    int n;
    lv[i] = 1'b1;
    ld[i] = d;
    acc[i] = 1'b0;
    n = 0;
    while (!acc[i] && n < 64) begin
      cyc();
      n++;
    end
    check($sformatf("u%0d_accept_in_time", i), acc[i], 1);
    lv[i] = 1'b0;
  endtask

  // Collect W bits from the current cycle on, in wire order
  // rebuilt into a word using the instance's bit ordering.
  task automatic grab(input int i, output logic [W-1:0] w);
    w = '0;
    for (int k = 0; k < W; k++) begin
      if (msb_of(i)) w = {w[W-2:0], dout[i]};
      else           w = {dout[i], w[W-1:1]};
      cyc();
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  logic [W-1:0] word;

  initial begin
    Rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      lv[i] = 1'b0;
      ld[i] = '0;
      acc[i] = 1'b0;
      ready_from[i] = 0;
    end
    @(posedge Clk);
    #1;
    chk_en = 1'b1;
    cyc();
    Rst = 1'b0;
    idle(2);

    // single word, MSB first
    send(0, 8'hA5);
    grab(0, word);
    check("u0_word_a5", word, 8'hA5);
    idle(2);

    // back-to-back, no bubble
    send(0, 8'hF0);
    send(0, 8'h0F);
    idle(10);

    // LSB first with forced gap
    send(1, 8'h01);
    grab(1, word);
    check("u1_word_01", word, 8'h01);
    send(1, 8'h80);
    grab(1, word);
    check("u1_word_80", word, 8'h80);
    idle(6);

    // reset on the 4th bit drops the word
    send(0, 8'hFF);
    idle(3);
    Rst = 1'b1;
    cyc();
    Rst = 1'b0;
    idle(2);
    send(0, 8'h81);
    grab(0, word);
    check("u0_word_81", word, 8'h81);

    // load pulse while not ready is ignored
    send(0, 8'h3C);
    idle(2);
    lv[0] = 1'b1;
    ld[0] = 8'h55;
    cyc();
    lv[0] = 1'b0;
    idle(12);
    check("u0_idle_after_pulse", bsy[0], 0);

    // randomized traffic with occasional resets
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!lv[i] || acc[i]) begin
          lv[i] = ($urandom_range(0, 2) != 0);
          ld[i] = W'($urandom);
        end
      end
      Rst = ($urandom_range(0, 199) == 0);
      cyc();
    end
    Rst = 1'b0;
    lv[0] = 1'b0;
    lv[1] = 1'b0;
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
